song_sequencer: RTL and testbench

Playback controller for `song_reader`. It turns single-cycle user pulses (play/pause, next) and the reader's `song_done` into the reader's `play`, `song` and `reset_player` controls. It handles manual skip, auto-advance at end of song, and wrap-around after the last song. It sits between the button one-pulse logic and `song_reader`.

---
 rtl/music_pkg.sv | 18 +
 rtl/song_sequencer_if.sv | 27 ++
 rtl/song_sequencer_lfsr8.sv | 19 +
 rtl/song_sequencer.sv | 116 +++++++++++
 tb/tb_song_sequencer.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared types and constants for the song playback controller
// Contents: seq_state_t FSM encoding, default song index width, LFSR seed/taps.
package music_pkg;

  typedef enum logic [1:0] {
    PAUSED    = 2'd0,
    PLAYING   = 2'd1,
    ADVANCE   = 2'd2,
    DONE_WAIT = 2'd3
  } seq_state_t;

  localparam int SONG_W_DEFAULT = 2;

  // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/song_sequencer_if.sv
// rtl/song_sequencer_if.sv - control/status bundle between buttons, sequencer and song_reader
// master: drives play_button, next_button, loop_all, song_done; observes play, song, reset_player, playing
// slave : the sequencer side (inputs/outputs reversed)
interface song_sequencer_if
  import music_pkg::*;
#(
  parameter int SONG_W = SONG_W_DEFAULT
);
  logic              play_button;
  logic              next_button;
  logic              loop_all;
  logic              song_done;
  logic              play;
  logic [SONG_W-1:0] song;
  logic              reset_player;
  logic              playing;

  modport master (
    output play_button, next_button, loop_all, song_done,
    input  play, song, reset_player, playing
  );

  modport slave (
    input  play_button, next_button, loop_all, song_done,
    output play, song, reset_player, playing
  );
endinterface

// File: rtl/song_sequencer_lfsr8.sv
// rtl/song_sequencer_lfsr8.sv - free-running 8-bit Fibonacci LFSR used to pick shuffled songs
// Ports: clk, reset (async active-low, loads seed), out[7:0] current LFSR state.
module lfsr8
  import music_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] out
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out <= LFSR_SEED;
    end else begin
      out <= {out[6:0], ^(out & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - playback FSM: play/pause, skip, auto-advance and wrap for song_reader
// Ports: clk, reset (async active-low), bus (song_sequencer_if.slave: buttons/song_done in,
//        play/song/reset_player/playing out; all outputs registered).
// Build option: SONG_SEQUENCER_SHUFFLE_EN selects LFSR-driven song order and disables the
//               stop after the last song; undefined gives sequential order with wrap.
module song_sequencer
  import music_pkg::*;
#(
  parameter int SONG_W = SONG_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  song_sequencer_if.slave   bus
);

  localparam logic [SONG_W-1:0] LAST_SONG = '1;

  seq_state_t        state;
  logic              play_q;
  logic              rp_q;
  logic              resume_q;
  logic [SONG_W-1:0] song_q;
  logic [SONG_W-1:0] next_song;
  logic              stop_at_end;

  assign bus.play         = play_q;
  assign bus.playing      = play_q;
  assign bus.song         = song_q;
  assign bus.reset_player = rp_q;

`ifdef SONG_SEQUENCER_SHUFFLE_EN
  logic [7:0] lfsr_out;
  logic       unused_loop_all;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .out   (lfsr_out)
  );

  // Never replay the current song: bump a colliding candidate by one.
  always_comb begin
    next_song = lfsr_out[SONG_W-1:0];
    if (next_song == song_q) begin
      next_song = next_song + 1'b1;
    end
  end

  assign stop_at_end     = 1'b0;
  assign unused_loop_all = bus.loop_all;
`else
  assign next_song   = song_q + 1'b1;
  assign stop_at_end = (song_q == LAST_SONG) && !bus.loop_all;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= PAUSED;
      play_q   <= 1'b0;
      rp_q     <= 1'b0;
      resume_q <= 1'b0;
      song_q   <= '0;
    end else begin
      rp_q <= 1'b0;
      case (state)
        PAUSED: begin
          if (bus.next_button) begin
            state    <= ADVANCE;
            resume_q <= 1'b0;
            rp_q     <= 1'b1;
            song_q   <= next_song;
          end else if (bus.play_button) begin
            state  <= PLAYING;
            play_q <= 1'b1;
          end
        end
        PLAYING: begin
          // next wins over song_done; either one gives a single advance
          if (bus.next_button || bus.song_done) begin
            state    <= ADVANCE;
            play_q   <= 1'b0;
            rp_q     <= 1'b1;
            song_q   <= next_song;
            resume_q <= bus.next_button || !stop_at_end;
          end else if (bus.play_button) begin
            state  <= PAUSED;
            play_q <= 1'b0;
          end
        end
        ADVANCE: begin
          // If song_done is already low there is nothing to wait for, so the
          // DONE_WAIT exit is taken directly; this lets a skip resume one cycle
          // after the reset_player pulse.
          if (bus.song_done) begin
            state <= DONE_WAIT;
          end else begin
            state  <= resume_q ? PLAYING : PAUSED;
            play_q <= resume_q;
          end
        end
        DONE_WAIT: begin
          resume_q <= resume_q ^ bus.play_button;
          if (!bus.song_done) begin
            state  <= (resume_q ^ bus.play_button) ? PLAYING : PAUSED;
            play_q <= resume_q ^ bus.play_button;
          end
        end
        default: begin
          state  <= PAUSED;
          play_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - scoreboard bench for song_sequencer (directed vectors)
module tb_song_sequencer;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  // expected output transactions: {play, reset_player, song}
  logic [3:0] exp_q[$];
  logic [3:0] prev    = 4'h0;
  logic [3:0] mon_cur;
  logic [3:0] mon_exp;
  bit         sb_en   = 1'b0;
  logic [3:0] seen;
  logic [1:0] last_song;

  always #5 clk = ~clk;

  song_sequencer_if #(.SONG_W(2)) bus ();

  song_sequencer #(.SONG_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic p, input logic rp, input logic [1:0] s);
    exp_q.push_back({p, rp, s});
  endtask

  task automatic pulse(input logic nb, input logic pb, input logic sd);
    bus.next_button = nb;
    bus.play_button = pb;
    bus.song_done   = sd;
    tick(1);
    bus.next_button = 1'b0;
    bus.play_button = 1'b0;
    bus.song_done   = 1'b0;
  endtask

  // Monitor: every change of the DUT outputs is one transaction to score.
  always @(negedge clk) begin
    mon_cur = {bus.play, bus.reset_player, bus.song};
    if (sb_en && (mon_cur !== prev)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected actual=%h expected=none", mon_cur);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_cur !== mon_exp) begin
          failures++;
          $display("FAIL sb_output actual={play,rp,song}=%b required=%b", mon_cur, mon_exp);
        end
      end
      check("playing_eq_play", bus.playing, bus.play);
    end
    prev = mon_cur;
  end

  initial begin
    bus.play_button = 1'b0;
    bus.next_button = 1'b0;
    bus.loop_all    = 1'b0;
    bus.song_done   = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("reset_state", {bus.play, bus.reset_player, bus.song, bus.playing}, 5'b0);
    tick(2);
    reset = 1'b1;
    sb_en = 1'b1;

`ifdef SONG_SEQUENCER_SHUFFLE_EN
    sb_en     = 1'b0;
    seen      = 4'h0;
    last_song = 2'd0;
    tick(3);
    for (int i = 0; i < 50; i++) begin
      bus.next_button = 1'b1;
      tick(1);
      bus.next_button = 1'b0;
      @(negedge clk);
      check("shuffle_rp", bus.reset_player, 1'b1);
      check("shuffle_new_song", (bus.song != last_song), 1'b1);
      seen[bus.song] = 1'b1;
      last_song      = bus.song;
      tick(2);
    end
    check("shuffle_coverage", seen, 4'hF);
`else
    tick(4);
    // play from reset: song 0, no reset_player pulse
    expect_out(1, 0, 2'd0); pulse(0, 1, 0); tick(3);
    // skips while playing
    expect_out(0, 1, 2'd1); expect_out(1, 0, 2'd1); pulse(1, 0, 0); tick(3);
    expect_out(0, 1, 2'd2); expect_out(1, 0, 2'd2); pulse(1, 0, 0); tick(3);
    expect_out(0, 1, 2'd3); expect_out(1, 0, 2'd3); pulse(1, 0, 0); tick(3);
    // last song ends, loop_all=0: wrap and pause
    bus.loop_all = 1'b0;
    expect_out(0, 1, 2'd0); expect_out(0, 0, 2'd0); pulse(0, 0, 1); tick(3);
    expect_out(1, 0, 2'd0); pulse(0, 1, 0); tick(3);
    // song_done held 5 cycles: one advance, DONE_WAIT, then resume
    expect_out(0, 1, 2'd1); expect_out(0, 0, 2'd1); expect_out(1, 0, 2'd1);
    bus.song_done = 1'b1; tick(5); bus.song_done = 1'b0; tick(3);
    expect_out(0, 1, 2'd2); expect_out(1, 0, 2'd2); pulse(1, 0, 0); tick(3);
    expect_out(0, 1, 2'd3); expect_out(1, 0, 2'd3); pulse(1, 0, 0); tick(3);
    // last song ends, loop_all=1: wrap and keep playing
    bus.loop_all = 1'b1;
    expect_out(0, 1, 2'd0); expect_out(1, 0, 2'd0); pulse(0, 0, 1); tick(3);
    // next + song_done + play together: single advance, still playing
    expect_out(0, 1, 2'd1); expect_out(1, 0, 2'd1); pulse(1, 1, 1); tick(3);
    // pause, then skip while paused stays paused
    expect_out(0, 0, 2'd1); pulse(0, 1, 0); tick(3);
    expect_out(0, 1, 2'd2); expect_out(0, 0, 2'd2); pulse(1, 0, 0); tick(3);
    // play pulse inside DONE_WAIT flips resume: paused skip ends up playing
    expect_out(0, 1, 2'd3); expect_out(0, 0, 2'd3); expect_out(1, 0, 2'd3);
    bus.next_button = 1'b1; bus.song_done = 1'b1; tick(1);
    bus.next_button = 1'b0; tick(1);
    bus.play_button = 1'b1; tick(1);
    bus.play_button = 1'b0; bus.song_done = 1'b0; tick(3);
    expect_out(0, 1, 2'd0); expect_out(1, 0, 2'd0); pulse(1, 0, 0); tick(3);
    // reset asserted during ADVANCE clears outputs at once, no pulse on release
    expect_out(0, 1, 2'd1); expect_out(0, 0, 2'd0);
    bus.next_button = 1'b1; tick(1); bus.next_button = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check("reset_mid_advance", {bus.play, bus.reset_player, bus.song, bus.playing}, 5'b0);
    tick(2);
    reset = 1'b1;
    tick(6);
    check("sb_drained", exp_q.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
